iis_rx_sample_fifo: RTL and testbench

- Downstream consumer of the I2S receive path. Takes the parallel 24-bit left/right words produced by iis_read_logic (ldata_l / rdata_l) and captures one stereo pair per lrclk frame.
- Buffers the pairs in a small FIFO and presents them on a valid/ready stream for DSP or a memory writer.
- Reports overflow: a sticky flag plus a saturating drop counter.
- Runs entirely in the clk_100m domain; lrclk is generated from that same clock.

---
 rtl/iis_rx_sample_fifo_if.sv | 23 ++
 rtl/iis_rx_sample_fifo.sv | 107 ++++++++++
 tb/tb_iis_rx_sample_fifo.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/iis_rx_sample_fifo_if.sv
// rtl/iis_rx_sample_fifo_if.sv - stereo sample stream (valid/ready) between FIFO and consumer
interface iis_rx_sample_fifo_if #(
  parameter int DW = 24
);
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_ldata;
  logic [DW-1:0] m_rdata;

  modport master (
    output m_valid,
    output m_ldata,
    output m_rdata,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_ldata,
    input  m_rdata,
    output m_ready
  );
endinterface

// File: rtl/iis_rx_sample_fifo.sv
// rtl/iis_rx_sample_fifo.sv - captures one L/R pair per lrclk frame into a FWFT FIFO with overflow stats
module iis_rx_sample_fifo #(
  parameter int DW          = 24,
  parameter int DEPTH       = 16,
  parameter int CAPTURE_DLY = 4,
  parameter int CNTW        = 16
) (
  input  logic                       clk_100m,
  input  logic                       rst_n,
  input  logic                       lrclk,
  input  logic [DW-1:0]              ldata_l,
  input  logic [DW-1:0]              rdata_l,
  input  logic                       en,
  input  logic                       clr_ovf,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  output logic [CNTW-1:0]            drop_cnt,
  iis_rx_sample_fifo_if.master       m
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (CAPTURE_DLY > 0) ? $clog2(CAPTURE_DLY + 1) : 1;
  localparam logic [CW-1:0] DLY_LOAD = (CAPTURE_DLY > 0) ? CW'(CAPTURE_DLY - 1) : '0;

  logic          lrclk_d;
  logic          dly_busy;
  logic [CW-1:0] dly_cnt;
  logic          fall, cap, pop, full, push_req, accept, drop;

  logic [2*DW-1:0] mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;

  // A fresh falling edge in the strobe cycle restarts the delay and suppresses the old strobe.
  always_comb begin
    fall     = lrclk_d & ~lrclk;
    cap      = (CAPTURE_DLY == 0) ? fall : (dly_busy && (dly_cnt == '0) && !fall);
    pop      = m.m_valid & m.m_ready;
    full     = (level == LW'(DEPTH));
    push_req = cap & en;
    accept   = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
  end

  assign m.m_valid = (level != '0);

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      lrclk_d  <= 1'b1;
      dly_busy <= 1'b0;
      dly_cnt  <= '0;
    end else begin
      lrclk_d <= lrclk;
      if (fall) begin
        dly_busy <= (CAPTURE_DLY != 0);
        dly_cnt  <= DLY_LOAD;
      end else if (dly_busy) begin
        if (dly_cnt == '0) dly_busy <= 1'b0;
        else               dly_cnt  <= dly_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100m) begin
    if (accept) mem[wptr] <= {ldata_l, rdata_l};
  end

  // Head registers give fall-through on an empty FIFO and hold the last head while empty.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      m.m_ldata <= '0;
      m.m_rdata <= '0;
    end else begin
      if (accept) wptr <= wptr + AW'(1);
      if (pop)    rptr <= rptr + AW'(1);
      case ({accept, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (accept && ((level == '0) || ((level == LW'(1)) && pop))) begin
        m.m_ldata <= ldata_l;
        m.m_rdata <= rdata_l;
      end else if (pop && (level > LW'(1))) begin
        {m.m_ldata, m.m_rdata} <= mem[rptr + AW'(1)];
      end
    end
  end

  // A drop in the clear cycle wins: the count restarts at one.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf      <= 1'b1;
      drop_cnt <= clr_ovf ? CNTW'(1) : ((&drop_cnt) ? drop_cnt : drop_cnt + 1'b1);
    end else if (clr_ovf) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_iis_rx_sample_fifo.sv
// tb/tb_iis_rx_sample_fifo.sv - self-checking bench for iis_rx_sample_fifo
module tb_iis_rx_sample_fifo;

  localparam int DW    = 24;
  localparam int DEPTH = 16;
  localparam int DLY   = 4;
  localparam int CNTW  = 2;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int MAXD  = (1 << CNTW) - 1;

  logic            clk_100m = 1'b0;
  logic            rst_n, lrclk, en, clr_ovf;
  logic [DW-1:0]   ldata_l, rdata_l;
  logic [LW-1:0]   level;
  logic            ovf;
  logic [CNTW-1:0] drop_cnt;

  iis_rx_sample_fifo_if #(.DW(DW)) s_if ();

  iis_rx_sample_fifo #(
    .DW(DW), .DEPTH(DEPTH), .CAPTURE_DLY(DLY), .CNTW(CNTW)
  ) dut (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .lrclk    (lrclk),
    .ldata_l  (ldata_l),
    .rdata_l  (rdata_l),
    .en       (en),
    .clr_ovf  (clr_ovf),
    .level    (level),
    .ovf      (ovf),
    .drop_cnt (drop_cnt),
    .m        (s_if.master)
  );

  always #5 clk_100m = ~clk_100m;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pairs plus a scheduled capture time per falling edge.
  logic [2*DW-1:0] mq[$];
  bit              m_ovf;
  int              m_drop;
  logic [DW-1:0]   m_last_l, m_last_r;
  bit              m_lr_prev;
  int              cyc, cap_at;

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_drop = 0;
    m_last_l = '0; m_last_r = '0;
    m_lr_prev = 1; cyc = 0; cap_at = -1;
  endtask

  task automatic model_step();
    bit fall, cap, pop, preq, dropped;
    fall    = m_lr_prev && !lrclk;
    if (fall) cap_at = cyc + DLY;
    cap     = (cap_at == cyc);
    pop     = (mq.size() > 0) && s_if.m_ready;
    preq    = cap && en;
    dropped = 0;
    if (pop) void'(mq.pop_front());
    if (preq) begin
      if (mq.size() < DEPTH) mq.push_back({ldata_l, rdata_l});
      else dropped = 1;
    end
    if (dropped) begin
      m_ovf  = 1;
      m_drop = clr_ovf ? 1 : ((m_drop < MAXD) ? m_drop + 1 : m_drop);
    end else if (clr_ovf) begin
      m_ovf = 0; m_drop = 0;
    end
    if (mq.size() > 0) {m_last_l, m_last_r} = mq[0];
    m_lr_prev = lrclk;
    cyc++;
  endtask

  task automatic check_all();
    chk("valid",  64'(s_if.m_valid), 64'(mq.size() > 0));
    chk("level",  64'(level),        64'(mq.size()));
    chk("ldata",  64'(s_if.m_ldata), 64'(m_last_l));
    chk("rdata",  64'(s_if.m_rdata), 64'(m_last_r));
    chk("ovf",    64'(ovf),          64'(m_ovf));
    chk("drop",   64'(drop_cnt),     64'(m_drop));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_100m);
    @(negedge clk_100m);
    check_all();
  endtask

  task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    ldata_l = l; rdata_l = r;
    lrclk = 1'b0; repeat (8) tick();
    lrclk = 1'b1; repeat (8) tick();
  endtask

  typedef struct {
    logic          lr;
    logic          ev;
    int            elvl;
    logic [DW-1:0] el;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int half, hcnt;

    tbl[0] = '{1'b1, 1'b0, 0, 24'h000000};
    tbl[1] = '{1'b0, 1'b0, 0, 24'h000000};
    tbl[2] = '{1'b0, 1'b0, 0, 24'h000000};
    tbl[3] = '{1'b0, 1'b0, 0, 24'h000000};
    tbl[4] = '{1'b0, 1'b0, 0, 24'h000000};
    tbl[5] = '{1'b0, 1'b1, 1, 24'h123456};
    tbl[6] = '{1'b0, 1'b0, 0, 24'h123456};
    tbl[7] = '{1'b1, 1'b0, 0, 24'h123456};

    rst_n = 1'b0; lrclk = 1'b1; en = 1'b1; clr_ovf = 1'b0;
    ldata_l = '0; rdata_l = '0; s_if.m_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_100m);
    chk("rst_valid", 64'(s_if.m_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_ovf",   64'(ovf), 64'd0);
    chk("rst_drop",  64'(drop_cnt), 64'd0);
    chk("rst_ldata", 64'(s_if.m_ldata), 64'd0);
    rst_n = 1'b1;

    // Basic capture: valid for exactly one cycle at N+5 with m_ready held
    s_if.m_ready = 1'b1;
    ldata_l = 24'h123456; rdata_l = 24'hABCDEF;
    for (int i = 0; i < 8; i++) begin
      lrclk = tbl[i].lr;
      tick();
      chk($sformatf("t1_valid[%0d]", i), 64'(s_if.m_valid), 64'(tbl[i].ev));
      chk($sformatf("t1_level[%0d]", i), 64'(level), 64'(tbl[i].elvl));
      chk($sformatf("t1_ldata[%0d]", i), 64'(s_if.m_ldata), 64'(tbl[i].el));
    end
    chk("t1_rdata", 64'(s_if.m_rdata), 64'hABCDEF);

    // Fill to overflow
    s_if.m_ready = 1'b0;
    for (int i = 1; i <= 18; i++) frame(DW'(i), DW'(i + 'h100));
    chk("t2_level", 64'(level), 64'd16);
    chk("t2_ovf",   64'(ovf), 64'd1);
    chk("t2_drop",  64'(drop_cnt), 64'd2);
    s_if.m_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("t2_drain[%0d]", k), 64'(s_if.m_ldata), 64'(k));
      tick();
    end
    chk("t2_empty", 64'(level), 64'd0);
    s_if.m_ready = 1'b0;

    // Full plus a pop in exactly the capture cycle
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    for (int i = 1; i <= 16; i++) frame(DW'(i + 'h300), DW'(i + 'h400));
    ldata_l = 24'h3FF; rdata_l = 24'h4FF;
    lrclk = 1'b0; tick();
    repeat (DLY - 1) tick();
    s_if.m_ready = 1'b1; tick(); s_if.m_ready = 1'b0;
    chk("t3_level", 64'(level), 64'd16);
    chk("t3_drop",  64'(drop_cnt), 64'd0);
    chk("t3_ovf",   64'(ovf), 64'd0);
    chk("t3_head",  64'(s_if.m_ldata), 64'h302);
    lrclk = 1'b1; repeat (4) tick();

    // Enable gating
    s_if.m_ready = 1'b1; repeat (16) tick(); s_if.m_ready = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 3; i++) frame(DW'(i + 'h500), DW'(i + 'h600));
    en = 1'b1;
    for (int i = 0; i < 2; i++) frame(DW'(i + 'h700), DW'(i + 'h800));
    chk("t4_level", 64'(level), 64'd2);
    chk("t4_drop",  64'(drop_cnt), 64'd0);
    chk("t4_head",  64'(s_if.m_ldata), 64'h700);
    s_if.m_ready = 1'b1; repeat (2) tick(); s_if.m_ready = 1'b0;

    // Saturation, clear, and clear colliding with a drop
    for (int i = 0; i < 21; i++) frame(DW'(i + 'h900), DW'(i + 'hA00));
    chk("t5_sat",   64'(drop_cnt), 64'(MAXD));
    chk("t5_ovf",   64'(ovf), 64'd1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("t5_clr_ovf",  64'(ovf), 64'd0);
    chk("t5_clr_drop", 64'(drop_cnt), 64'd0);
    lrclk = 1'b0; tick();
    repeat (DLY - 1) tick();
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("t5_coll_ovf",  64'(ovf), 64'd1);
    chk("t5_coll_drop", 64'(drop_cnt), 64'd1);
    lrclk = 1'b1; repeat (4) tick();

    // Asynchronous reset with entries buffered and a capture pending
    s_if.m_ready = 1'b1; repeat (11) tick(); s_if.m_ready = 1'b0;
    chk("t6_pre_level", 64'(level), 64'd5);
    lrclk = 1'b0; tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 64'(s_if.m_valid), 64'd0);
    chk("t6_level", 64'(level), 64'd0);
    chk("t6_ovf",   64'(ovf), 64'd0);
    chk("t6_drop",  64'(drop_cnt), 64'd0);
    chk("t6_ldata", 64'(s_if.m_ldata), 64'd0);
    @(negedge clk_100m);
    lrclk = 1'b1; rst_n = 1'b1;
    model_reset();
    repeat (10) tick();
    chk("t6_nostale", 64'(level), 64'd0);
    frame(24'hC0FFEE, 24'hBEEF00);
    chk("t6_first", 64'(level), 64'd1);

    // Randomized traffic including short frames that abort pending captures
    half = 8; hcnt = 0;
    for (int c = 0; c < 600; c++) begin
      if (hcnt >= half) begin
        lrclk = ~lrclk; hcnt = 0; half = $urandom_range(3, 12);
      end
      hcnt++;
      ldata_l      = DW'($urandom);
      rdata_l      = DW'($urandom);
      en           = ($urandom % 4) != 0;
      s_if.m_ready = ($urandom % 3) == 0;
      clr_ovf      = ($urandom % 25) == 0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
